// File: rtl/ss_display_arbiter_if.sv
// Bus between the two display requesters and the seven-segment arbiter.
// The master side is the requester pair. The slave side is the arbiter,
// which drives the grants, the acks and the digit/brightness outputs.
interface ss_display_arbiter_if;
    logic        req_a;
    logic [15:0] data_a;
    logic        req_b;
    logic [15:0] data_b;
    logic        grant_a;
    logic        grant_b;
    logic        ack_a;
    logic        ack_b;
    logic [3:0]  BCD3;
    logic [3:0]  BCD2;
    logic [3:0]  BCD1;
    logic [3:0]  BCD0;
    logic [7:0]  pwm_out;
    logic        busy;

    modport master (
        output req_a, data_a, req_b, data_b,
        input  grant_a, grant_b, ack_a, ack_b,
        input  BCD3, BCD2, BCD1, BCD0, pwm_out, busy
    );

    modport slave (
        input  req_a, data_a, req_b, data_b,
        output grant_a, grant_b, ack_a, ack_b,
        output BCD3, BCD2, BCD1, BCD0, pwm_out, busy
    );
endinterface

// File: rtl/ss_display_arbiter.sv
// Round-robin owner of the 4-digit seven-segment display for two requesters.
// Ownership change sequence: fade out to 0, release, re-arbitrate, latch the
// new owner's digits, fade in to MAX_BRIGHT. The new owner then holds the
// display for at least HOLD_CYCLES before the other side can take it.
module ss_display_arbiter #(
    parameter int unsigned HOLD_CYCLES = 100000000,
    parameter int unsigned STEP_CYCLES = 390625,
    parameter logic [7:0]  FADE_INC    = 8'd1,
    parameter logic [7:0]  MAX_BRIGHT  = 8'hFF
) (
    input logic                 Clk,
    input logic                 Reset,
    ss_display_arbiter_if.slave bus
);

    localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int unsigned STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] FADE_IN  = 2'd1;
    localparam logic [1:0] SHOW     = 2'd2;
    localparam logic [1:0] FADE_OUT = 2'd3;

    logic [1:0]        state;
    logic [HOLD_W-1:0] hold_cnt;
    logic [STEP_W-1:0] step_cnt;
    logic              last_owner_b;   // 1 = B owned last, so A wins the next tie

    logic        pick_a;
    logic        pick_b;
    logic [15:0] pick_data;
    logic        owner_req;
    logic        other_req;
    logic [15:0] owner_data;
    logic [8:0]  pwm_sum;
    logic [7:0]  pwm_up;
    logic [7:0]  pwm_down;
    logic        step_wrap;
    logic        hold_done;

    // Arbitration choice, owner view of the requests, and saturating fade arithmetic.
    // NOTE: every signal here is assigned on every pass, so no latch can be inferred.
    always_comb begin
        pick_a     = bus.req_a && (!bus.req_b || last_owner_b);
        pick_b     = bus.req_b && !pick_a;
        pick_data  = pick_a ? bus.data_a : bus.data_b;
        owner_req  = bus.grant_a ? bus.req_a  : bus.req_b;
        other_req  = bus.grant_a ? bus.req_b  : bus.req_a;
        owner_data = bus.grant_a ? bus.data_a : bus.data_b;
        pwm_sum    = {1'b0, bus.pwm_out} + {1'b0, FADE_INC};
        pwm_up     = (pwm_sum > {1'b0, MAX_BRIGHT}) ? MAX_BRIGHT : pwm_sum[7:0];
        pwm_down   = (bus.pwm_out > FADE_INC) ? (bus.pwm_out - FADE_INC) : 8'd0;
        step_wrap  = (step_cnt == STEP_LAST);
        hold_done  = (hold_cnt == HOLD_LAST);
    end

    // Ownership FSM: all outputs, counters and the digit latch are registered here.
    // NOTE: non-blocking assignments keep every register reading the pre-edge values.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state        <= IDLE;
            hold_cnt     <= '0;
            step_cnt     <= '0;
            last_owner_b <= 1'b1;
            bus.grant_a  <= 1'b0;
            bus.grant_b  <= 1'b0;
            bus.ack_a    <= 1'b0;
            bus.ack_b    <= 1'b0;
            bus.pwm_out  <= 8'd0;
            bus.busy     <= 1'b0;
            {bus.BCD3, bus.BCD2, bus.BCD1, bus.BCD0} <= 16'h0000;
        end else begin
            bus.ack_a <= 1'b0;
            bus.ack_b <= 1'b0;
            case (state)
                IDLE: begin
                    bus.pwm_out <= 8'd0;
                    if (pick_a || pick_b) begin
                        {bus.BCD3, bus.BCD2, bus.BCD1, bus.BCD0} <= pick_data;
                        bus.grant_a <= pick_a;
                        bus.grant_b <= pick_b;
                        bus.ack_a   <= pick_a;
                        bus.ack_b   <= pick_b;
                        step_cnt    <= '0;
                        bus.busy    <= 1'b1;
                        state       <= FADE_IN;
                    end
                end
                FADE_IN: begin
                    if (step_wrap) begin
                        step_cnt    <= '0;
                        bus.pwm_out <= pwm_up;
                        if (pwm_up == MAX_BRIGHT) begin
                            hold_cnt <= '0;
                            state    <= SHOW;
                        end
                    end else begin
                        step_cnt <= step_cnt + STEP_W'(1);
                    end
                end
                SHOW: begin
                    bus.pwm_out <= MAX_BRIGHT;
                    // Live digit update while the owner keeps requesting; frozen otherwise.
                    if (owner_req) begin
                        {bus.BCD3, bus.BCD2, bus.BCD1, bus.BCD0} <= owner_data;
                    end
                    if (!hold_done) begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                    if (hold_done && other_req) begin
                        step_cnt <= '0;
                        state    <= FADE_OUT;
                    end
                end
                FADE_OUT: begin
                    if (step_wrap) begin
                        step_cnt    <= '0;
                        bus.pwm_out <= pwm_down;
                        if (pwm_down == 8'd0) begin
                            last_owner_b <= bus.grant_b;
                            bus.grant_a  <= 1'b0;
                            bus.grant_b  <= 1'b0;
                            bus.busy     <= 1'b0;
                            state        <= IDLE;
                        end
                    end else begin
                        step_cnt <= step_cnt + STEP_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ss_display_arbiter.sv
// Self-checking bench for ss_display_arbiter. Expected brightness comes from
// the closed-form fade ramps. Expected owner comes from the round-robin rule.
// Expected digits come from a tracked "what the display should show" value.
module tb_ss_display_arbiter;

    localparam int HOLD     = 8;
    localparam int STEP     = 2;
    localparam int INC      = 64;
    localparam int MAXB     = 255;
    localparam int FADE_LEN = ((MAXB + INC - 1) / INC) * STEP;

    logic        Clk = 1'b0;
    logic        Reset;
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          last_b;      // model: previous owner was B
    logic [15:0] exp_bcd;     // model: digits the display should show

    ss_display_arbiter_if bus();

    ss_display_arbiter #(
        .HOLD_CYCLES(HOLD),
        .STEP_CYCLES(STEP),
        .FADE_INC   (8'(INC)),
        .MAX_BRIGHT (8'(MAXB))
    ) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .bus  (bus)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Brightness t cycles after a grant / after the switch edge.
    function automatic int fade_in_pwm(int t);
        int v = (t / STEP) * INC;
        return (v > MAXB) ? MAXB : v;
    endfunction

    function automatic int fade_out_pwm(int t);
        int v = MAXB - (t / STEP) * INC;
        return (v < 0) ? 0 : v;
    endfunction

    // Inputs change at the falling edge; outputs are sampled there too.
    task automatic tick;
        @(posedge Clk);
        @(negedge Clk);
    endtask

    function automatic logic [15:0] bcd();
        return {bus.BCD3, bus.BCD2, bus.BCD1, bus.BCD0};
    endfunction

    function automatic logic [15:0] data_of(bit who);
        return who ? bus.data_b : bus.data_a;
    endfunction

    task automatic set_req(bit who, logic v);
        if (who) bus.req_b = v; else bus.req_a = v;
    endtask

    task automatic set_data(bit who, logic [15:0] d);
        if (who) bus.data_b = d; else bus.data_a = d;
    endtask

    // {grant_a, grant_b, ack_a, ack_b}
    function automatic logic [3:0] gvec(bit owned, bit who, bit ack);
        if (!owned) return 4'b0000;
        return who ? {2'b01, 1'b0, ack} : {2'b10, ack, 1'b0};
    endfunction

    task automatic check_grant_vec(string tag, logic [3:0] exp);
        check(tag, {bus.grant_a, bus.grant_b, bus.ack_a, bus.ack_b}, exp);
    endtask

    task automatic expect_grant(string tag, bit who);
        check_grant_vec({tag, "_grant"}, gvec(1'b1, who, 1'b1));
        check({tag, "_bcd"}, bcd(), exp_bcd);
        check({tag, "_pwm"}, bus.pwm_out, 0);
        check({tag, "_busy"}, bus.busy, 1);
    endtask

    task automatic run_fade_in(string tag, bit who);
        for (int t = 1; t <= FADE_LEN; t++) begin
            tick;
            check({tag, "_fin_pwm"}, bus.pwm_out, fade_in_pwm(t));
            check_grant_vec({tag, "_fin_grant"}, gvec(1'b1, who, 1'b0));
            check({tag, "_fin_bcd"}, bcd(), exp_bcd);
        end
    endtask

    // SHOW phase. s counts edges since SHOW was entered; the other side
    // requests from edge other_from on. A switch happens on the first
    // edge with s >= HOLD that samples the other request.
    task automatic run_show(string tag, bit who, int s_start, int other_from, bit rnd);
        bit switched = 1'b0;
        for (int s = s_start; s < s_start + 64; s++) begin
            logic oreq;
            if (rnd) begin
                set_req(who, 1'($urandom_range(0, 1)));
                set_data(who, 16'($urandom));
            end
            set_req(!who, s >= other_from);
            oreq = who ? bus.req_b : bus.req_a;
            tick;
            if (oreq) exp_bcd = data_of(who);
            check({tag, "_show_pwm"}, bus.pwm_out, MAXB);
            check({tag, "_show_bcd"}, bcd(), exp_bcd);
            check_grant_vec({tag, "_show_grant"}, gvec(1'b1, who, 1'b0));
            if (s >= HOLD && s >= other_from) begin
                switched = 1'b1;
                break;
            end
        end
        check({tag, "_show_switch_reached"}, switched, 1);
    endtask

    task automatic run_fade_out(string tag, bit who, int ncyc, bit rnd);
        for (int t = 1; t <= ncyc; t++) begin
            if (rnd) begin
                set_data(who, 16'($urandom));
                bus.req_a = 1'($urandom_range(0, 1));
                bus.req_b = 1'($urandom_range(0, 1));
            end
            tick;
            check({tag, "_fout_pwm"}, bus.pwm_out, fade_out_pwm(t));
            check({tag, "_fout_bcd"}, bcd(), exp_bcd);
            check_grant_vec({tag, "_fout_grant"}, gvec(t < FADE_LEN, who, 1'b0));
            check({tag, "_fout_busy"}, bus.busy, t < FADE_LEN);
        end
        if (ncyc >= FADE_LEN) last_b = who;
    endtask

    task automatic episode;
        int   idle_n = $urandom_range(0, 2);
        int   r;
        bit   winner;
        for (int i = 0; i < idle_n; i++) begin
            bus.req_a  = 1'b0;
            bus.req_b  = 1'b0;
            bus.data_a = 16'($urandom);
            bus.data_b = 16'($urandom);
            tick;
            check_grant_vec("rnd_idle_grant", 4'b0000);
            check("rnd_idle_pwm", bus.pwm_out, 0);
            check("rnd_idle_busy", bus.busy, 0);
            check("rnd_idle_bcd", bcd(), exp_bcd);
        end
        r          = $urandom_range(1, 3);
        bus.req_a  = r[0];
        bus.req_b  = r[1];
        bus.data_a = 16'($urandom);
        bus.data_b = 16'($urandom);
        winner     = (r[0] && r[1]) ? !last_b : r[1];
        exp_bcd    = data_of(winner);
        tick;
        expect_grant("rnd", winner);
        run_fade_in("rnd", winner);
        run_show("rnd", winner, 1, $urandom_range(1, 12), 1'b1);
        run_fade_out("rnd", winner, FADE_LEN, 1'b1);
    endtask

    initial begin
        // Reset held for three edges while A is already requesting.
        Reset      = 1'b0;
        bus.req_a  = 1'b1;
        bus.data_a = 16'h1234;
        bus.req_b  = 1'b0;
        bus.data_b = 16'h0000;
        repeat (3) tick;
        check_grant_vec("reset_grant", 4'b0000);
        check("reset_pwm", bus.pwm_out, 0);
        check("reset_bcd", bcd(), 16'h0000);
        check("reset_busy", bus.busy, 0);
        last_b = 1'b1;

        // Single request from A: grant and ack one edge after release.
        Reset   = 1'b1;
        exp_bcd = 16'h1234;
        tick;
        expect_grant("single_a", 1'b0);
        run_fade_in("single_a", 1'b0);

        // Live update while A requests, then frozen after A drops.
        bus.data_a = 16'h5678;
        tick;
        exp_bcd = 16'h5678;
        check("live_bcd", bcd(), exp_bcd);
        check_grant_vec("live_noack", gvec(1'b1, 1'b0, 1'b0));
        bus.req_a  = 1'b0;
        bus.data_a = 16'h9ABC;
        tick;
        check("frozen_bcd", bcd(), exp_bcd);

        // B asks at hold count 2; the switch waits for the hold to saturate.
        run_show("switch_ab", 1'b0, 3, 3, 1'b0);
        bus.data_b = 16'h9087;
        run_fade_out("switch_ab", 1'b0, FADE_LEN, 1'b0);
        exp_bcd = 16'h9087;
        tick;
        expect_grant("switch_ab_b", 1'b1);
        run_fade_in("owner_b", 1'b1);

        // A requests back; reset lands while FADE_OUT shows 127.
        run_show("owner_b", 1'b1, 1, 1, 1'b0);
        run_fade_out("midfade", 1'b1, 4, 1'b0);
        check("midfade_pwm_before_reset", bus.pwm_out, 127);
        Reset = 1'b0;
        tick;
        check("midfade_reset_pwm", bus.pwm_out, 0);
        check_grant_vec("midfade_reset_grant", 4'b0000);
        check("midfade_reset_busy", bus.busy, 0);
        check("midfade_reset_bcd", bcd(), 16'h0000);
        last_b = 1'b1;

        // Tie straight after reset goes to A.
        bus.req_a  = 1'b1;
        bus.req_b  = 1'b1;
        bus.data_a = 16'hA1B2;
        bus.data_b = 16'hC3D4;
        Reset      = 1'b1;
        exp_bcd    = 16'hA1B2;
        tick;
        expect_grant("tie_a", 1'b0);
        run_fade_in("tie_a", 1'b0);
        run_show("tie_a", 1'b0, 1, 5, 1'b1);
        run_fade_out("tie_a", 1'b0, FADE_LEN, 1'b1);

        // Randomised ownership episodes against the rule-level model.
        for (int e = 0; e < 16; e++) episode();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
